// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: data width, RV32 load/store
// funct3 codes and the controller state encoding.
package dmem_ctrl_pkg;

  localparam int DMEM_XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    CAPT = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte enables / lane replication / legality
// check for an incoming request, and lane extract plus sign/zero extension for loads.
module dmem_lane_align import dmem_ctrl_pkg::*; #(
  parameter int XLEN = DMEM_XLEN
) (
  input  logic              we,
  input  logic [2:0]        func3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic              illegal,
  input  logic [2:0]        ld_func3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   rdata_ext
);
  localparam int NB = XLEN / 8;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    illegal   = 1'b0;
    if (we) begin
      case (func3)
        SB: begin
          be        = NB'(1) << off;
          wdata_rep = {NB{wdata[7:0]}};
        end
        SH: begin
          be        = off[1] ? NB'(4'b1100) : NB'(4'b0011);
          wdata_rep = {(XLEN/16){wdata[15:0]}};
          illegal   = off[0];
        end
        SW: begin
          be      = NB'(4'b1111);
          illegal = (off != 2'b00);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (func3)
        LB, LBU:  illegal = 1'b0;
        LH, LHU:  illegal = off[0];
        LW:       illegal = (off != 2'b00);
        default:  illegal = 1'b1;
      endcase
    end
  end

  // Lane selection uses the offset captured with the request, not the live address.
  always_comb begin
    byte_sel  = rdata[{ld_off, 3'b000} +: 8];
    half_sel  = rdata[{ld_off[1], 4'b0000} +: 16];
    rdata_ext = '0;
    case (ld_func3)
      LB:      rdata_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     rdata_ext = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      rdata_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     rdata_ext = {{(XLEN-16){1'b0}}, half_sel};
      LW:      rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store per handshake, drives a single-port
// synchronous SRAM with configurable read wait states, registered response.
module dmem_ctrl import dmem_ctrl_pkg::*; #(
  parameter int XLEN        = DMEM_XLEN,
  parameter int AW          = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [2:0]        func3_i,
  output logic              ready_o,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [XLEN/8-1:0] sram_be_o,
  output logic [AW-1:0]     sram_addr_o,
  output logic [XLEN-1:0]   sram_wdata_o,
  input  logic [XLEN-1:0]   sram_rdata_i
);
  localparam int         NB        = XLEN / 8;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic              cap_we_reg;
  logic [2:0]        cap_func3_reg;
  logic [1:0]        cap_off_reg;
  logic [AW-1:0]     cap_addr_reg;
  logic [NB-1:0]     cap_be_reg;
  logic [XLEN-1:0]   cap_wdata_reg;
  logic              resp_valid_reg;
  logic              err_reg;
  logic [XLEN-1:0]   rdata_reg;

  logic              accept;
  logic              illegal_req;
  logic [NB-1:0]     be_req;
  logic [XLEN-1:0]   wdata_req;
  logic [XLEN-1:0]   rdata_ext;
  logic              unused_addr;

  // Word address wraps: address bits above the SRAM range are dropped.
  assign unused_addr = ^addr_i[XLEN-1:AW+2];
  assign accept      = req_i && (state_reg == IDLE);

  dmem_lane_align #(.XLEN(XLEN)) u_lane (
    .we        (we_i),
    .func3     (func3_i),
    .off       (addr_i[1:0]),
    .wdata     (wdata_i),
    .be        (be_req),
    .wdata_rep (wdata_req),
    .illegal   (illegal_req),
    .ld_func3  (cap_func3_reg),
    .ld_off    (cap_off_reg),
    .rdata     (sram_rdata_i),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !illegal_req) state_next = CMD;
      CMD:     if (cap_we_reg)             state_next = IDLE;
               else if (WAIT_CYCLES > 0)   state_next = WAIT;
               else                        state_next = CAPT;
      WAIT:    if (cnt_reg == WAIT_LAST)   state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM pins decode from state so an async reset clears them without a clock.
  always_comb begin
    ready_o      = (state_reg == IDLE);
    sram_ce_o    = (state_reg == CMD);
    sram_we_o    = (state_reg == CMD) && cap_we_reg;
    sram_be_o    = ((state_reg == CMD) && cap_we_reg) ? cap_be_reg : '0;
    sram_addr_o  = (state_reg == CMD) ? cap_addr_reg : '0;
    sram_wdata_o = ((state_reg == CMD) && cap_we_reg) ? cap_wdata_reg : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               cnt_reg <= '0;
    else if (state_reg == CMD)  cnt_reg <= '0;
    else if (state_reg == WAIT) cnt_reg <= cnt_reg + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_we_reg    <= 1'b0;
      cap_func3_reg <= '0;
      cap_off_reg   <= '0;
      cap_addr_reg  <= '0;
      cap_be_reg    <= '0;
      cap_wdata_reg <= '0;
    end else if (accept && !illegal_req) begin
      cap_we_reg    <= we_i;
      cap_func3_reg <= func3_i;
      cap_off_reg   <= addr_i[1:0];
      cap_addr_reg  <= addr_i[AW+1:2];
      cap_be_reg    <= be_req;
      cap_wdata_reg <= wdata_req;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (accept && illegal_req) begin
        resp_valid_reg <= 1'b1;
        err_reg        <= 1'b1;
        rdata_reg      <= '0;
      end else if ((state_reg == CMD) && cap_we_reg) begin
        resp_valid_reg <= 1'b1;
        err_reg        <= 1'b0;
      end else if (state_reg == CAPT) begin
        resp_valid_reg <= 1'b1;
        err_reg        <= 1'b0;
        rdata_reg      <= rdata_ext;
      end
    end
  end

  assign resp_valid_o = resp_valid_reg;
  assign err_o        = err_reg;
  assign rdata_o      = rdata_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 3 read wait states), each with an SRAM
// model, checked every cycle against a byte-addressed transaction model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  func3;

  logic        ready [2];
  logic        resp_valid [2];
  logic        err [2];
  logic        sram_ce [2];
  logic        sram_we [2];
  logic [31:0] rdata [2];
  logic [31:0] sram_wdata [2];
  logic [31:0] sram_rdata [2];
  logic [3:0]  sram_be [2];
  logic [13:0] sram_addr [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.XLEN(32), .AW(14), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .func3_i(func3), .ready_o(ready[0]), .resp_valid_o(resp_valid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .sram_ce_o(sram_ce[0]), .sram_we_o(sram_we[0]),
    .sram_be_o(sram_be[0]), .sram_addr_o(sram_addr[0]), .sram_wdata_o(sram_wdata[0]),
    .sram_rdata_i(sram_rdata[0])
  );

  dmem_ctrl #(.XLEN(32), .AW(14), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .func3_i(func3), .ready_o(ready[1]), .resp_valid_o(resp_valid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .sram_ce_o(sram_ce[1]), .sram_we_o(sram_we[1]),
    .sram_be_o(sram_be[1]), .sram_addr_o(sram_addr[1]), .sram_wdata_o(sram_wdata[1]),
    .sram_rdata_i(sram_rdata[1])
  );

  function automatic int wait_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int f_size(logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit f_legal(bit w, logic [2:0] f, logic [31:0] a);
    int sz;
    sz = f_size(f);
    if (w && f > 3'd2) return 1'b0;
    if (!w && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b0;
    return (a & 32'(sz - 1)) == 32'd0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM model: read data appears exactly 1+W cycles after the CMD cycle.
  logic [31:0] smem [2][0:16383];
  logic [31:0] pend_data [2];
  int          pend_cnt [2];
  logic        pend_v [2];

  always @(posedge clk) begin : sram_p
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend_v[k]   <= 1'b0;
        pend_cnt[k] <= 0;
      end else if (sram_ce[k]) begin
        if (sram_we[k]) begin
          w = smem[k][sram_addr[k]];
          for (int b = 0; b < 4; b++)
            if (sram_be[k][b]) w[8*b +: 8] = sram_wdata[k][8*b +: 8];
          smem[k][sram_addr[k]] <= w;
          pend_v[k] <= 1'b0;
        end else begin
          pend_data[k] <= smem[k][sram_addr[k]];
          pend_cnt[k]  <= wait_of(k);
          pend_v[k]    <= 1'b1;
        end
      end else if (pend_cnt[k] > 0) begin
        pend_cnt[k] <= pend_cnt[k] - 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      sram_rdata[k] = (pend_v[k] && pend_cnt[k] == 0) ? pend_data[k] : 32'hBADC0DE5;
  end

  // Transaction model: cycle index since accept, latency, and expected results.
  logic [7:0]  mb [2][0:65535];
  int          m_cyc [2] = '{0, 0};
  int          m_lat [2] = '{1, 1};
  logic        m_legal [2];
  logic        m_store [2];
  logic [31:0] m_rd [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_be [2];
  logic [13:0] m_addr [2];

  always @(posedge clk or negedge rst_n) begin : model_p
    int          sz;
    int          base;
    logic [31:0] v;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) m_cyc[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k] == 0 || m_cyc[k] == m_lat[k]) begin
          if (req[k]) begin
            sz   = f_size(func3);
            base = int'(addr[15:0]);
            m_cyc[k]   <= 1;
            m_store[k] <= we;
            m_legal[k] <= f_legal(we, func3, addr);
            m_addr[k]  <= addr[15:2];
            if (!f_legal(we, func3, addr)) begin
              m_lat[k] <= 1;
              m_rd[k]  <= 32'd0;
            end else if (we) begin
              m_lat[k] <= 2;
              for (int i = 0; i < sz; i++) mb[k][(base + i) & 16'hFFFF] = wdata[8*i +: 8];
              m_be[k] <= 4'((1 << sz) - 1) << addr[1:0];
              m_wd[k] <= (sz == 1) ? wdata[7:0] * 32'h01010101 :
                         (sz == 2) ? wdata[15:0] * 32'h00010001 : wdata;
            end else begin
              m_lat[k] <= 3 + wait_of(k);
              v = 32'd0;
              for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[k][(base + i) & 16'hFFFF];
              if (!func3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
              if (!func3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
              m_rd[k] <= v;
            end
          end else begin
            m_cyc[k] <= 0;
          end
        end else begin
          m_cyc[k] <= m_cyc[k] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  logic [31:0] hold [2];

  always @(posedge clk) begin : check_p
    int          c;
    int          l;
    logic [31:0] exp_rd;
    #3;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("rst ready%0d", k), 32'(ready[k]), 32'd1);
        chk($sformatf("rst resp%0d", k), 32'(resp_valid[k]), 32'd0);
        chk($sformatf("rst err%0d", k), 32'(err[k]), 32'd0);
        chk($sformatf("rst rdata%0d", k), rdata[k], 32'd0);
        chk($sformatf("rst sram%0d", k),
            {sram_wdata[k] | 32'(sram_addr[k]) | 32'(sram_be[k])}, 32'd0);
        chk($sformatf("rst ce_we%0d", k), 32'({sram_ce[k], sram_we[k]}), 32'd0);
        hold[k] = 32'd0;
      end else begin
        c = m_cyc[k];
        l = m_lat[k];
        chk($sformatf("ready%0d", k), 32'(ready[k]), 32'(c == 0 || c == l));
        chk($sformatf("resp%0d", k), 32'(resp_valid[k]), 32'(c != 0 && c == l));
        chk($sformatf("ce%0d", k), 32'(sram_ce[k]), 32'(c == 1 && m_legal[k]));
        if (c == 1 && m_legal[k]) begin
          chk($sformatf("sram_we%0d", k), 32'(sram_we[k]), 32'(m_store[k]));
          chk($sformatf("sram_be%0d", k), 32'(sram_be[k]), m_store[k] ? 32'(m_be[k]) : 32'd0);
          chk($sformatf("sram_addr%0d", k), 32'(sram_addr[k]), 32'(m_addr[k]));
          if (m_store[k]) chk($sformatf("sram_wdata%0d", k), sram_wdata[k], m_wd[k]);
        end
        if (c != 0 && c == l) begin
          chk($sformatf("err%0d", k), 32'(err[k]), 32'(!m_legal[k]));
          exp_rd = (m_store[k] && m_legal[k]) ? hold[k] : m_rd[k];
          chk($sformatf("resp rdata%0d", k), rdata[k], exp_rd);
          hold[k] = exp_rd;
        end else begin
          chk($sformatf("held rdata%0d", k), rdata[k], hold[k]);
        end
      end
    end
  end

  // Called at edge+1 of the first cycle after accept; returns the response cycle.
  task automatic wait_resp(int k, output int lat, output logic ce_s,
                           output logic [3:0] be_s, output logic [31:0] wd_s);
    lat  = 1;
    ce_s = 1'b0;
    be_s = 4'd0;
    wd_s = 32'd0;
    while (1) begin
      if (sram_ce[k]) begin
        ce_s = 1'b1;
        be_s = sram_be[k];
        wd_s = sram_wdata[k];
      end
      if (resp_valid[k] || lat >= 40) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic txn(string nm, int k, bit w, logic [2:0] f, logic [31:0] a,
                     logic [31:0] wd, int exp_lat, logic [31:0] exp_rd, bit exp_err,
                     logic [3:0] exp_be, logic [31:0] exp_wd);
    int          n;
    int          lat;
    logic        ce_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    @(negedge clk);
    we = w; func3 = f; addr = a; wdata = wd; req[k] = 1'b1;
    n = 0;
    while (!ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, 32'(ready[k]), 32'd1);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    wait_resp(k, lat, ce_s, be_s, wd_s);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " err"}, 32'(err[k]), 32'(exp_err));
    chk({nm, " rdata"}, rdata[k], exp_rd);
    chk({nm, " ce"}, 32'(ce_s), 32'(!exp_err));
    if (!exp_err) chk({nm, " be"}, 32'(be_s), 32'(exp_be));
    if (w && !exp_err) chk({nm, " wdata"}, wd_s, exp_wd);
    $display("txn %-12s dut%0d lat=%0d rdata=%h err=%0d be=%b", nm, k, lat, rdata[k], err[k], be_s);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin : main_p
    int          lat;
    int          pulses;
    logic        ce_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    rst_n = 1'b0; req = 2'b00; we = 1'b0; addr = 32'd0; wdata = 32'd0; func3 = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // W=0: word, byte and half stores/loads
    txn("SW 1000",   0, 1, 3'b010, 32'h1000, 32'hDEADBEEF, 2, 32'h0,        0, 4'b1111, 32'hDEADBEEF);
    txn("LW 1000",   0, 0, 3'b010, 32'h1000, 32'h0,        3, 32'hDEADBEEF, 0, 4'b0000, 32'h0);
    txn("SB 1003",   0, 1, 3'b000, 32'h1003, 32'h000000A5, 2, 32'hDEADBEEF, 0, 4'b1000, 32'hA5A5A5A5);
    txn("LB 1003",   0, 0, 3'b000, 32'h1003, 32'h0,        3, 32'hFFFFFFA5, 0, 4'b0000, 32'h0);
    txn("LBU 1003",  0, 0, 3'b100, 32'h1003, 32'h0,        3, 32'h000000A5, 0, 4'b0000, 32'h0);
    txn("SH 1002",   0, 1, 3'b001, 32'h1002, 32'h00008001, 2, 32'h000000A5, 0, 4'b1100, 32'h80018001);
    txn("LH 1002",   0, 0, 3'b001, 32'h1002, 32'h0,        3, 32'hFFFF8001, 0, 4'b0000, 32'h0);
    txn("LHU 1002",  0, 0, 3'b101, 32'h1002, 32'h0,        3, 32'h00008001, 0, 4'b0000, 32'h0);
    txn("SB 1001",   0, 1, 3'b000, 32'h1001, 32'h0000007F, 2, 32'h00008001, 0, 4'b0010, 32'h7F7F7F7F);
    txn("LB 1001",   0, 0, 3'b000, 32'h1001, 32'h0,        3, 32'h0000007F, 0, 4'b0000, 32'h0);
    txn("LW wrap",   0, 0, 3'b010, 32'hFFFF1000, 32'h0,    3, 32'h80017FEF, 0, 4'b0000, 32'h0);

    // Illegal accesses: one-cycle error response, no SRAM cycle
    txn("LW 1001",   0, 0, 3'b010, 32'h1001, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0);
    txn("SH 1001",   0, 1, 3'b001, 32'h1001, 32'h1234,     1, 32'h0,        1, 4'b0000, 32'h0);
    txn("LD f3=011", 0, 0, 3'b011, 32'h1000, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0);
    txn("ST f3=100", 0, 1, 3'b100, 32'h1000, 32'h0,        1, 32'h0,        1, 4'b0000, 32'h0);
    txn("LHU 1000",  0, 0, 3'b101, 32'h1000, 32'h0,        3, 32'h00007FEF, 0, 4'b0000, 32'h0);

    // W=3: preload, then a held request behind a long load
    txn("SW3 1000",  1, 1, 3'b010, 32'h1000, 32'hDEADBEEF, 2, 32'h0,        0, 4'b1111, 32'hDEADBEEF);
    txn("SW3 1004",  1, 1, 3'b010, 32'h1004, 32'h12345678, 2, 32'h0,        0, 4'b1111, 32'h12345678);

    @(negedge clk);
    we = 1'b0; func3 = 3'b010; addr = 32'h1000; req[1] = 1'b1;
    @(posedge clk);
    #1;
    addr = 32'h1004;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t4 ready c%0d", c), 32'(ready[1]), 32'(c == 6));
      chk($sformatf("t4 ce c%0d", c), 32'(sram_ce[1]), 32'(c == 1));
      chk($sformatf("t4 resp c%0d", c), 32'(resp_valid[1]), 32'(c == 6));
      if (c < 6) begin
        @(posedge clk);
        #1;
      end
    end
    chk("t4 first rdata", rdata[1], 32'hDEADBEEF);
    $display("txn %-12s dut1 lat=6 rdata=%h", "LW3 1000", rdata[1]);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    wait_resp(1, lat, ce_s, be_s, wd_s);
    chk("t4 second latency", 32'(lat), 32'd6);
    chk("t4 second rdata", rdata[1], 32'h12345678);
    $display("txn %-12s dut1 lat=%0d rdata=%h", "LW3 1004", lat, rdata[1]);

    // Reset during WAIT aborts the load
    @(negedge clk);
    we = 1'b0; func3 = 3'b010; addr = 32'h1000; req[1] = 1'b1;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #2;
    chk("t6 ce in reset", 32'(sram_ce[1]), 32'd0);
    chk("t6 resp in reset", 32'(resp_valid[1]), 32'd0);
    chk("t6 ready in reset", 32'(ready[1]), 32'd1);
    chk("t6 rdata in reset", rdata[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid[1]) pulses++;
    end
    chk("t6 no response after abort", 32'(pulses), 32'd0);
    $display("txn %-12s dut1 aborted by reset, pulses=%0d", "LW3 abort", pulses);
    txn("LW3 post",  1, 0, 3'b010, 32'h1000, 32'h0,        6, 32'hDEADBEEF, 0, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
